// File: rtl/seq_shift_add_multiplier_if.sv
// seq_shift_add_multiplier_if: operand/result handshake bundle for the shift-add multiplier.
interface seq_shift_add_multiplier_if #(parameter int WIDTH = 8);
   logic in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
   logic [WIDTH-1:0] a, b;
   logic [2*WIDTH-1:0] product;
   modport master (output in_valid, a, b, signed_mode, out_ready, input in_ready, out_valid, product, busy);
   modport slave (input in_valid, a, b, signed_mode, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: iterative signed/unsigned shift-and-add multiplier, one multiplier bit per clock.
module seq_shift_add_multiplier #(parameter int WIDTH = 8) (
   input logic clk,
   input logic rst_n,
   seq_shift_add_multiplier_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] mcand, mplier, acc;
   logic [CW-1:0] count;
   logic neg, last;
   logic [WIDTH:0] sum;
   logic [2*WIDTH-1:0] mag;
   assign sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
   // magnitude as it will look after this step's right shift
   assign mag = {sum, mplier[WIDTH-1:1]};
   assign last = count == CW'(WIDTH - 1);
   always_comb begin
      state_nx = state == IDLE ? (bus.in_valid ? CALC : IDLE) :
                 state == CALC ? (last ? DONE : CALC) :
                 (bus.out_ready ? IDLE : DONE);
      bus.in_ready = state == IDLE;
      bus.out_valid = state == DONE;
      bus.busy = state != IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand <= '0;
         mplier <= '0;
         acc <= '0;
         count <= '0;
         neg <= 1'b0;
         bus.product <= '0;
      end else if (state == IDLE && bus.in_valid) begin
         mcand <= bus.signed_mode && bus.a[WIDTH-1] ? -bus.a : bus.a;
         mplier <= bus.signed_mode && bus.b[WIDTH-1] ? -bus.b : bus.b;
         neg <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         acc <= '0;
         count <= '0;
      end else if (state == CALC) begin
         acc <= sum[WIDTH:1];
         mplier <= {sum[0], mplier[WIDTH-1:1]};
         count <= count + CW'(1);
         if (last) bus.product <= neg ? -mag : mag;
      end
   end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: directed checks on an 8-bit instance plus an exhaustive 4-bit sweep.
module tb_seq_shift_add_multiplier;
   logic clk = 0, rst_n = 0;
   int n_chk = 0, n_pass = 0;
   seq_shift_add_multiplier_if #(.WIDTH(8)) m8 ();
   seq_shift_add_multiplier_if #(.WIDTH(4)) m4 ();
   seq_shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(m8.slave));
   seq_shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(m4.slave));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sm, input logic [15:0] exp);
      int nb, lat;
      m8.a = a;
      m8.b = b;
      m8.signed_mode = sm;
      m8.in_valid = 1;
      m8.out_ready = 1;
      step();
      m8.in_valid = 0;
      nb = 0;
      lat = -1;
      while (m8.busy && nb < 40) begin
         if (m8.out_valid && lat < 0) lat = nb;
         nb++;
         step();
      end
      chk({tag, "_lat"}, lat, 8);
      chk({tag, "_busy"}, nb, 9);
      chk({tag, "_prod"}, m8.product, exp);
      chk({tag, "_rdy"}, m8.in_ready, 1);
   endtask

   initial begin
      int t;
      logic got;
      m8.in_valid = 0; m8.a = 0; m8.b = 0; m8.signed_mode = 0; m8.out_ready = 1;
      m4.in_valid = 0; m4.a = 0; m4.b = 0; m4.signed_mode = 0; m4.out_ready = 1;
      #12;
      chk("rst_in_ready", m8.in_ready, 1);
      chk("rst_out_valid", m8.out_valid, 0);
      chk("rst_busy", m8.busy, 0);
      chk("rst_product", m8.product, 0);
      @(negedge clk);
      rst_n = 1;
      step();
      mul8("u_ff_ff", 8'hFF, 8'hFF, 0, 16'hFE01);
      mul8("s_m3_5", 8'hFD, 8'h05, 1, 16'hFFF1);
      mul8("s_80_80", 8'h80, 8'h80, 1, 16'h4000);
      mul8("s_80_01", 8'h80, 8'h01, 1, 16'hFF80);
      mul8("s_0_ab", 8'h00, 8'hAB, 1, 16'h0000);
      mul8("u_01_9c", 8'h01, 8'h9C, 0, 16'h009C);
      mul8("s_m1_m1", 8'hFF, 8'hFF, 1, 16'h0001);
      // backpressure: result held, new operands ignored
      m8.out_ready = 0;
      m8.a = 12; m8.b = 10; m8.signed_mode = 0; m8.in_valid = 1;
      step();
      m8.in_valid = 0;
      t = 0;
      while (!m8.out_valid && t < 30) begin t++; step(); end
      chk("bp_lat", t, 8);
      for (int i = 0; i < 5; i++) begin
         m8.in_valid = 1; m8.a = 1; m8.b = 1;
         step();
         chk("bp_valid", m8.out_valid, 1);
         chk("bp_in_ready", m8.in_ready, 0);
         chk("bp_prod", m8.product, 16'h0078);
      end
      m8.out_ready = 1;
      step();
      m8.in_valid = 0;
      chk("bp_idle_rdy", m8.in_ready, 1);
      chk("bp_idle_busy", m8.busy, 0);
      chk("bp_idle_valid", m8.out_valid, 0);
      chk("bp_idle_prod", m8.product, 16'h0078);
      step();
      chk("bp_no_accept", m8.busy, 0);
      // asynchronous reset in the middle of a calculation
      m8.a = 200; m8.b = 3; m8.in_valid = 1;
      step();
      m8.in_valid = 0;
      repeat (3) @(posedge clk);
      #2;
      chk("mid_busy", m8.busy, 1);
      rst_n = 0;
      #1;
      chk("mid_rst_ready", m8.in_ready, 1);
      chk("mid_rst_busy", m8.busy, 0);
      chk("mid_rst_valid", m8.out_valid, 0);
      chk("mid_rst_prod", m8.product, 0);
      @(negedge clk);
      rst_n = 1;
      mul8("after_rst", 8'd7, 8'd6, 0, 16'd42);
      // exhaustive 4-bit sweep with random consumer stalls
      for (int sm = 0; sm < 2; sm++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
               int ea, eb;
               logic [7:0] exp;
               ea = (sm == 1 && a >= 8) ? a - 16 : a;
               eb = (sm == 1 && b >= 8) ? b - 16 : b;
               exp = 8'(ea * eb);
               m4.a = 4'(a); m4.b = 4'(b); m4.signed_mode = sm[0]; m4.in_valid = 1;
               step();
               m4.in_valid = 0;
               t = 0;
               got = 0;
               while (!got && t < 100) begin
                  m4.out_ready = 1'($urandom_range(0, 1));
                  if (m4.out_valid && m4.out_ready) begin
                     chk($sformatf("w4_%0d_%0h_%0h", sm, a, b), m4.product, exp);
                     got = 1;
                  end
                  step();
                  t++;
               end
               if (!got) chk("w4_timeout", t, 0);
            end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
